// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, drives the
// datapath selects, traps illegal opcodes and counts retired instructions.
module multicycle_control #(
   parameter bit          SUPPORT_IMM_ALU = 1'b1,
   parameter bit          SUPPORT_JAL     = 1'b1,
   parameter bit          SUPPORT_BNE     = 1'b1,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             zero,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             RegWrite,
   output logic [1:0]       ImmSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StAluWb    = 4'd7,
      StExecI    = 4'd8,
      StJal      = 4'd9,
      StBranch   = 4'd10,
      StTrap     = 4'd11
   } state_e;

   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       pc_update;
      logic       branch;
   } ctrl_t;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpImmAlu = 7'b0010011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             taken;
   logic             unused_funct3;

   function automatic ctrl_t ctrl_for(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         StFetch: begin
            c.ir_write   = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.pc_update  = 1'b1;
         end
         StDecode: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         StMemAdr: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         StMemRead: c.adr_src = 1'b1;
         StMemWb: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         StMemWrite: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         StExecR: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b10;
         end
         StAluWb: c.reg_write = 1'b1;
         StExecI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b10;
         end
         // Target was computed into ALUOut during DECODE; ALU now forms OldPC+4 for rd.
         StJal: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_update = 1'b1;
         end
         StBranch: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b01;
            c.branch    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecR;
               OpImmAlu:        state_d = SUPPORT_IMM_ALU ? StExecI : StTrap;
               OpJal:           state_d = SUPPORT_JAL ? StJal : StTrap;
               OpBranch:        state_d = StBranch;
               default:         state_d = StTrap;
            endcase
         end
         StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecR:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StExecI:    state_d = StAluWb;
         StJal:      state_d = StAluWb;
         StBranch:   state_d = StFetch;
         StTrap:     state_d = StTrap;
         default:    state_d = StFetch;
      endcase
   end

   always_comb begin
      ctrl_d    = ctrl_for(state_d);
      illegal_d = (state_d == StTrap);
      instret_d = instret_q;
      // Only the final state of each instruction retires it.
      if (state_q inside {StMemWb, StMemWrite, StAluWb, StBranch}) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StFetch;
         ctrl_q    <= ctrl_for(StFetch);
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OpStore:  ImmSrc = 2'b01;
         OpBranch: ImmSrc = 2'b10;
         OpJal:    ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   // With bne disabled funct3 is ignored and every branch compares for equality.
   assign taken         = zero ^ (SUPPORT_BNE & funct3[0]);
   assign unused_funct3 = ^funct3[2:1];

   assign PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & taken);
   assign AdrSrc    = ctrl_q.adr_src;
   assign MemWrite  = ctrl_q.mem_write;
   assign IRWrite   = ctrl_q.ir_write;
   assign ResultSrc = ctrl_q.result_src;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign ALUSrcB   = ctrl_q.alu_src_b;
   assign ALUOp     = ctrl_q.alu_op;
   assign RegWrite  = ctrl_q.reg_write;
   assign illegal   = illegal_q;
   assign instret   = instret_q;
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of instructions checked cycle by cycle, plus
// hand-written trap, reset, disabled-JAL and counter-wrap sequences on a second instance.
module tb_multicycle_control;

   logic        clk;
   logic        rst;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        zero;

   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [31:0] instret;
   logic [3:0]  state;

   logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal2;
   logic [1:0]  result_src2, alu_src_a2, alu_src_b2, alu_op2, imm_src2;
   logic [3:0]  instret2;
   logic [3:0]  state2;

   int unsigned n_pass;
   int unsigned n_total;

   multicycle_control dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .funct3    (funct3),
      .zero      (zero),
      .PCWrite   (pc_write),
      .AdrSrc    (adr_src),
      .MemWrite  (mem_write),
      .IRWrite   (ir_write),
      .ResultSrc (result_src),
      .ALUSrcA   (alu_src_a),
      .ALUSrcB   (alu_src_b),
      .ALUOp     (alu_op),
      .RegWrite  (reg_write),
      .ImmSrc    (imm_src),
      .illegal   (illegal),
      .instret   (instret),
      .state     (state)
   );

   multicycle_control #(
      .SUPPORT_JAL (1'b0),
      .CNT_W       (4)
   ) dut2 (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .funct3    (funct3),
      .zero      (zero),
      .PCWrite   (pc_write2),
      .AdrSrc    (adr_src2),
      .MemWrite  (mem_write2),
      .IRWrite   (ir_write2),
      .ResultSrc (result_src2),
      .ALUSrcA   (alu_src_a2),
      .ALUSrcB   (alu_src_b2),
      .ALUOp     (alu_op2),
      .RegWrite  (reg_write2),
      .ImmSrc    (imm_src2),
      .illegal   (illegal2),
      .instret   (instret2),
      .state     (state2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        zero;
      int unsigned len;
      logic [19:0] seq;    // states as nibbles, first state in the top nibble
      logic        br_pc;  // expected PCWrite in BRANCH
      logic [1:0]  imm;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal}
   function automatic logic [12:0] exp_ctrl(input logic [3:0] s);
      case (s)
         4'd0:    return 13'b0_0_1_10_00_10_00_0_0;
         4'd1:    return 13'b0_0_0_00_01_01_00_0_0;
         4'd2:    return 13'b0_0_0_00_10_01_00_0_0;
         4'd3:    return 13'b1_0_0_00_00_00_00_0_0;
         4'd4:    return 13'b0_0_0_01_00_00_00_1_0;
         4'd5:    return 13'b1_1_0_00_00_00_00_0_0;
         4'd6:    return 13'b0_0_0_00_10_00_10_0_0;
         4'd7:    return 13'b0_0_0_00_00_00_00_1_0;
         4'd8:    return 13'b0_0_0_00_10_01_10_0_0;
         4'd9:    return 13'b0_0_0_00_01_10_00_0_0;
         4'd10:   return 13'b0_0_0_00_10_00_01_0_0;
         4'd11:   return 13'b0_0_0_00_00_00_00_0_1;
         default: return 13'b0;
      endcase
   endfunction

   function automatic logic [12:0] act_ctrl();
      return {adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op,
              reg_write, illegal};
   endfunction

   initial begin
      logic [19:0] sq;
      logic [3:0]  st;
      logic        exp_pc;

      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{7'b0000011, 3'b000, 1'b0, 5, 20'h01234, 1'b0, 2'b00};  // lw
      vecs[1] = '{7'b0100011, 3'b010, 1'b0, 4, 20'h01250, 1'b0, 2'b01};  // sw
      vecs[2] = '{7'b0110011, 3'b000, 1'b0, 4, 20'h01670, 1'b0, 2'b00};  // R-type
      vecs[3] = '{7'b0010011, 3'b000, 1'b0, 4, 20'h01870, 1'b0, 2'b00};  // addi
      vecs[4] = '{7'b1101111, 3'b000, 1'b0, 4, 20'h01970, 1'b0, 2'b11};  // jal
      vecs[5] = '{7'b1100011, 3'b000, 1'b1, 3, 20'h01A00, 1'b1, 2'b10};  // beq taken
      vecs[6] = '{7'b1100011, 3'b000, 1'b0, 3, 20'h01A00, 1'b0, 2'b10};  // beq not taken
      vecs[7] = '{7'b1100011, 3'b001, 1'b1, 3, 20'h01A00, 1'b0, 2'b10};  // bne not taken
      vecs[8] = '{7'b1100011, 3'b001, 1'b0, 3, 20'h01A00, 1'b1, 2'b10};  // bne taken

      rst    = 1'b1;
      op     = 7'b0000011;
      funct3 = 3'b000;
      zero   = 1'b0;
      step();
      step();
      check("reset.state", 32'(state), 32'd0);
      check("reset.illegal", 32'(illegal), 32'd0);
      check("reset.instret", instret, 32'd0);
      check("reset.ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd0)));
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         op     = vecs[k].op;
         funct3 = vecs[k].f3;
         zero   = vecs[k].zero;
         sq     = vecs[k].seq;
         #1;
         check($sformatf("v%0d.immsrc", k), 32'(imm_src), 32'(vecs[k].imm));
         for (int i = 0; i < int'(vecs[k].len); i++) begin
            st = sq[19-4*i -: 4];
            exp_pc = (st == 4'd0) || (st == 4'd9) || ((st == 4'd10) && vecs[k].br_pc);
            check($sformatf("v%0d.c%0d.state", k, i), 32'(state), 32'(st));
            check($sformatf("v%0d.c%0d.ctrl", k, i), 32'(act_ctrl()), 32'(exp_ctrl(st)));
            check($sformatf("v%0d.c%0d.pcwrite", k, i), 32'(pc_write), 32'(exp_pc));
            step();
         end
         check($sformatf("v%0d.end_state", k), 32'(state), 32'd0);
         check($sformatf("v%0d.instret", k), instret, 32'(k + 1));
      end

      // Illegal opcode: trap is sticky and freezes instret.
      op = 7'b1111111;
      check("trap.fetch", 32'(state), 32'd0);
      step();
      check("trap.decode", 32'(state), 32'd1);
      check("trap.decode_illegal", 32'(illegal), 32'd0);
      step();
      check("trap.state", 32'(state), 32'd11);
      check("trap.ctrl", 32'(act_ctrl()), 32'(exp_ctrl(4'd11)));
      check("trap.pcwrite", 32'(pc_write), 32'd0);
      repeat (3) step();
      check("trap.stays", 32'(state), 32'd11);
      check("trap.illegal_sticky", 32'(illegal), 32'd1);
      check("trap.instret_frozen", instret, 32'd9);

      // Reset out of TRAP.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("trap_rst.state", 32'(state), 32'd0);
      check("trap_rst.illegal", 32'(illegal), 32'd0);
      check("trap_rst.instret", instret, 32'd0);
      check("trap_rst.state2", 32'(state2), 32'd0);
      check("trap_rst.illegal2", 32'(illegal2), 32'd0);

      // jal: legal on dut, trap on dut2 (SUPPORT_JAL=0).
      op = 7'b1101111;
      step();
      check("jal.decode", 32'(state), 32'd1);
      step();
      check("jal.state", 32'(state), 32'd9);
      check("jal.pcwrite", 32'(pc_write), 32'd1);
      check("jal_off.state2", 32'(state2), 32'd11);
      check("jal_off.illegal2", 32'(illegal2), 32'd1);
      step();
      check("jal.aluwb", 32'(state), 32'd7);
      step();
      check("jal.fetch", 32'(state), 32'd0);
      check("jal.instret", instret, 32'd1);
      check("jal_off.instret2", 32'(instret2), 32'd0);

      // Reset while in MEMREAD.
      op = 7'b0000011;
      repeat (3) step();
      check("midrst.memread", 32'(state), 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst.state", 32'(state), 32'd0);
      check("midrst.illegal", 32'(illegal), 32'd0);
      check("midrst.instret", instret, 32'd0);
      check("midrst.memwrite", 32'(mem_write), 32'd0);
      check("midrst.regwrite", 32'(reg_write), 32'd0);
      step();
      check("midrst.next_state", 32'(state), 32'd1);
      check("midrst.next_memwrite", 32'(mem_write), 32'd0);
      check("midrst.next_regwrite", 32'(reg_write), 32'd0);

      // Counter wrap on the 4-bit instance: 17 R-type instructions.
      rst = 1'b1;
      step();
      rst = 1'b0;
      op     = 7'b0110011;
      funct3 = 3'b000;
      for (int n = 1; n <= 17; n++) begin
         repeat (4) step();
         if (n >= 15) begin
            check($sformatf("wrap.instret2_n%0d", n), 32'(instret2), 32'(n % 16));
         end
      end
      check("wrap.state2", 32'(state2), 32'd0);
      check("wrap.instret_wide", instret, 32'd17);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Registered control unit for the multi-cycle RV32I datapath. It supersedes the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-ALU and memory-port select signals.
- Adds I-type ALU, JAL and BNE support, each selectable by parameter, plus an illegal-opcode trap and a retired-instruction counter.

Parameters:
SUPPORT_IMM_ALU, 1, when 1, opcode 0010011 is legal; when 0, it traps.
SUPPORT_JAL, 1, when 1, opcode 1101111 is legal; when 0, it traps.
SUPPORT_BNE, 1, when 1, branch funct3=001 is bne; when 0, every branch is beq.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
op  in  7  opcode from the instruction register.
funct3  in  3  funct3 from the instruction register.
zero  in  1  ALU zero flag.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
MemWrite  out  1  data memory write strobe.
IRWrite  out  1  instruction register enable.
ResultSrc  out  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult.
ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
ALUSrcB  out  2  ALU B select: 00=rs2, 01=Imm, 10=constant 4.
ALUOp  out  2  to alu_decoder: 00=add, 01=sub, 10=funct-decoded.
RegWrite  out  1  register file write enable.
ImmSrc  out  2  immediate format select.
illegal  out  1  sticky trap flag.
instret  out  CNT_W  retired-instruction count.
state  out  4  current state, for debug.

Behaviour:
General output rules:
- All outputs except ImmSrc and PCWrite are pure functions of the current state (Moore).
- Any output not listed for a state is 0.
- ImmSrc is combinational from op: 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; anything else gives 00.
- PCWrite = PCUpdate | (Branch & taken).
  - taken = zero ^ (SUPPORT_BNE & funct3[0]).

Reset:
- rst=1 at a clock edge sets state=FETCH, illegal=0 and instret=0.
- This applies from any state, including mid-instruction and TRAP.

States (encoding, outputs, next state):
- FETCH (0): IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE (1): ALUSrcA=01, ALUSrcB=01. Next state is chosen from op:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1101111 goes to JAL.
  - 1100011 goes to BRANCH.
  - Any other opcode, or an opcode whose feature is disabled, goes to TRAP.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD (3): AdrSrc=1. Next: MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE (5): AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECR (6): ALUSrcA=10, ALUOp=10. Next: ALUWB.
- ALUWB (7): RegWrite=1. Next: FETCH.
- EXECI (8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- JAL (9): ALUSrcA=01, ALUSrcB=10, PCUpdate=1. Next: ALUWB.
  - The PC takes the target held in ALUOut from DECODE; rd takes OldPC+4 in ALUWB.
- BRANCH (10): ALUSrcA=10, ALUOp=01, Branch=1. Next: FETCH.
- TRAP (11): illegal=1, all strobes 0. Stays in TRAP until rst.
- Encodings 12-15 are unreachable; if entered, next state is FETCH.

Latency in cycles, counted from the FETCH cycle through the last state:
- lw: 5.
- sw: 4.
- R-type: 4.
- I-type ALU: 4.
- jal: 4.
- branch: 3.

instret:
- Increments by 1 on each edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH to FETCH.
- Wraps modulo 2^CNT_W with no saturation.
- Does not increment in TRAP.

op and funct3 are only sampled in DECODE, MEMADR and BRANCH. The instruction register is stable in those states.

Test Plan:
- Reset and lw: hold rst for 2 cycles, then op=0000011.
  - Required: state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; instret=1 after the return to FETCH.
- sw then R-type: op=0100011, then op=0110011.
  - Required: MemWrite=1 for exactly one cycle, with AdrSrc=1.
  - Required: the R-type passes states 6 and 7 with ALUOp=10 in state 6; instret=2.
- Branches with SUPPORT_BNE=1:
  - beq with zero=1: PCWrite=1 in BRANCH.
  - bne (funct3=001) with zero=1: PCWrite=0.
  - bne with zero=0: PCWrite=1.
  - Each branch takes 3 cycles.
- Illegal opcodes:
  - op=1111111: FETCH, DECODE, then TRAP; illegal=1 and stays set; instret is frozen.
  - With SUPPORT_JAL=0 and op=1101111: also ends in TRAP.
- Reset mid-operation: assert rst while in MEMREAD.
  - Required: next state FETCH, illegal=0, instret=0, MemWrite and RegWrite low on the following cycle.
- Counter wrap: CNT_W=4, run 17 R-type instructions.
  - Required: instret reads 15, then 0, then 1.
